// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory bus adapter.
//   dmem_state_t           : adapter FSM state encoding (2 bits)
//   WORD_ALIGN_MASK        : clears the byte-offset bits of an address
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit for the MEM_TIMEOUT_EN build
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  // Wide enough for any practical ADDR_W; users slice [ADDR_W-1:0].
  localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dmem_timeout.sv
// -----------------------------------------------------------------------------
// dmem_timeout
// Watchdog for the data-memory bus adapter. Compiled only when MEM_TIMEOUT_EN
// is defined; the adapter instantiates it only in that build.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse on the cycle the adapter enters REQ (clears the count)
//   busy      : adapter is in REQ or WAIT (count advances)
//   expired   : this is the TIMEOUT_CYCLES-th busy cycle of the transaction
// -----------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
module dmem_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  output logic expired
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Count holds k-1 during the k-th busy cycle, so this fires on the last allowed one.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = busy && (cnt == LIMIT);

endmodule
`endif

// File: rtl/dmem_bus_adapter.sv
// -----------------------------------------------------------------------------
// dmem_bus_adapter
// Turns one memory-stage access into one valid/ready data-memory bus
// transaction, stalling the pipeline until it completes, and returns the raw
// read word for the load-wrap logic.
// Optional feature macro: MEM_TIMEOUT_EN (watchdog + bus_error pulse).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   request, we_re      : access request this cycle; 1 = store, 0 = load
//   mask, address       : byte enables and effective address
//   store_data          : pre-shifted store data
//   load_data           : registered read data (held until the next load)
//   stall               : pipeline hold while an access is outstanding
//   bus_error           : one-cycle pulse on watchdog expiry (0 w/o feature)
//   mem_valid/mem_ready : request handshake
//   mem_we, mem_mask, mem_addr, mem_wdata : latched request fields
//   mem_rvalid, mem_rdata : read response
// -----------------------------------------------------------------------------
module dmem_bus_adapter
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              we_re,
  input  logic [3:0]        mask,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              bus_error,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  dmem_state_t state, state_next;
  logic        capture_req;
  logic        capture_load;
  logic        timeout_hit;
  logic        expired;

`ifdef MEM_TIMEOUT_EN
  logic busy;
  assign busy = (state == REQ) || (state == WAIT);

  dmem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (capture_req),
    .busy    (busy),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expired        = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_next   = state;
    capture_req  = 1'b0;
    capture_load = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          capture_req = 1'b1;
          state_next  = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (mem_we) begin
            state_next = DONE;
          end else if (mem_rvalid) begin
            capture_load = 1'b1;
            state_next   = DONE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          capture_load = 1'b1;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A genuine completion in the expiry cycle wins over the watchdog.
    if (expired && (state_next != DONE)) begin
      timeout_hit = 1'b1;
      state_next  = DONE;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_mask  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      state <= state_next;
      if (capture_req) begin
        mem_addr  <= address & WORD_ALIGN_MASK[ADDR_W-1:0];
        mem_mask  <= mask;
        mem_wdata <= store_data;
        mem_we    <= we_re;
      end
      if (capture_load) begin
        load_data <= mem_rdata;
      end else if (timeout_hit) begin
        load_data <= '0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic bus_error_q;
  always_ff @(posedge clk) begin
    if (rst) bus_error_q <= 1'b0;
    else     bus_error_q <= timeout_hit;
  end
  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  assign mem_valid = (state == REQ);
  // Stall covers the request cycle itself so the instruction never leaves
  // memory before the adapter has captured it; DONE releases the pipeline.
  assign stall     = ((state == IDLE) && request) || (state == REQ) || (state == WAIT);

endmodule
